// File: rtl/wb_reg_bank_pkg.sv
// wb_reg_bank_pkg: shared widths and encodings for the operand path.
//   - DATA_BUS / REG_IDX_BUS       : datapath and register-index widths
//   - ALU_A_OP_*                   : ALU operand-A source selects
//   - WB_DEST_OP_*                 : write-back destination encodings (6-7 reserved)
//   - wb_we_t                      : decoded one-hot write enables
//   - SP_RESET_DEFAULT             : stack pointer value after reset
package wb_reg_bank_pkg;

  localparam int unsigned DATA_BUS       = 16;
  localparam int unsigned REG_IDX_BUS    = 3;
  localparam int unsigned ALU_A_OP_BUS   = 3;
  localparam int unsigned WB_DEST_OP_BUS = 3;

  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_REGA = 3'd0;
  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_T    = 3'd1;
  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_SP   = 3'd2;
  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_IH   = 3'd3;
  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_RA   = 3'd4;
  localparam logic [ALU_A_OP_BUS-1:0] ALU_A_OP_PC   = 3'd5;

  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_NONE = 3'd0;
  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_REG  = 3'd1;
  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_T    = 3'd2;
  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_SP   = 3'd3;
  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_IH   = 3'd4;
  localparam logic [WB_DEST_OP_BUS-1:0] WB_DEST_OP_RA   = 3'd5;

  localparam logic [DATA_BUS-1:0] SP_RESET_DEFAULT = 16'hBF00;

  typedef struct packed {
    logic reg_we;
    logic t_we;
    logic sp_we;
    logic ih_we;
    logic ra_we;
  } wb_we_t;

  // Ops 6 and 7 are reserved.
  function automatic logic is_reserved_op(input logic [WB_DEST_OP_BUS-1:0] op);
    return op > WB_DEST_OP_RA;
  endfunction

endpackage

// File: rtl/wb_reg_bank_dest_decode.sv
// wb_dest_decode: combinational write-back destination decoder.
// Ports:
//   wb_en, wb_stall, wb_dest_op : write-back control from MEM/WB
//   we                          : one-hot write enables (all zero unless committing)
//   commit_done                 : a real destination is written this cycle
//   err                         : reserved op presented with wb_en=1
module wb_dest_decode
  import wb_reg_bank_pkg::*;
(
  input  logic                      wb_en,
  input  logic                      wb_stall,
  input  logic [WB_DEST_OP_BUS-1:0] wb_dest_op,
  output wb_we_t                    we,
  output logic                      commit_done,
  output logic                      err
);

  logic w_go;

  assign w_go = wb_en & ~wb_stall;

  always_comb begin
    we          = '0;
    commit_done = 1'b0;
    err         = 1'b0;
    case (wb_dest_op)
      WB_DEST_OP_NONE: ;
      WB_DEST_OP_REG:  we.reg_we = w_go;
      WB_DEST_OP_T:    we.t_we   = w_go;
      WB_DEST_OP_SP:   we.sp_we  = w_go;
      WB_DEST_OP_IH:   we.ih_we  = w_go;
      WB_DEST_OP_RA:   we.ra_we  = w_go;
      default: ;
    endcase
    commit_done = |we;
    // Error flags the arrival of a reserved op, independent of the stall.
    err = wb_en & is_reserved_op(wb_dest_op);
  end

endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: write-back register bank (R0-R7, T, SP, IH, RA).
// Optional macro: WB_REG_BYPASS_EN forwards a committing write to the
// matching read output in the same cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   wb_en, wb_stall          : write-back valid / pipeline hold
//   wb_dest_op, wb_reg_idx   : destination select and general-register index
//   wb_data                  : write value
//   rx_idx, ry_idx           : read indices for REGA / REGB
//   data_REGA .. data_RA     : read data
//   wb_done                  : one-cycle pulse after a committed write
//   wb_err                   : sticky reserved-op flag
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int unsigned          DATA_W   = DATA_BUS,
  parameter int unsigned          REG_NUM  = 8,
  parameter int unsigned          IDX_W    = $clog2(REG_NUM),
  parameter logic [DATA_W-1:0]    SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_en,
  input  logic                      wb_stall,
  input  logic [WB_DEST_OP_BUS-1:0] wb_dest_op,
  input  logic [IDX_W-1:0]          wb_reg_idx,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic [IDX_W-1:0]          rx_idx,
  input  logic [IDX_W-1:0]          ry_idx,
  output logic [DATA_W-1:0]         data_REGA,
  output logic [DATA_W-1:0]         data_REGB,
  output logic [DATA_W-1:0]         data_T,
  output logic [DATA_W-1:0]         data_SP,
  output logic [DATA_W-1:0]         data_IH,
  output logic [DATA_W-1:0]         data_RA,
  output logic                      wb_done,
  output logic                      wb_err
);

  wb_we_t            w_we;
  logic              w_commit_done;
  logic              w_err;

  logic [DATA_W-1:0] r_gpr [REG_NUM];
  logic [DATA_W-1:0] r_t;
  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_ih;
  logic [DATA_W-1:0] r_ra;
  logic              r_done;
  logic              r_err;

  wb_dest_decode u_dest_decode (
    .wb_en       (wb_en),
    .wb_stall    (wb_stall),
    .wb_dest_op  (wb_dest_op),
    .we          (w_we),
    .commit_done (w_commit_done),
    .err         (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_we.reg_we) begin
      r_gpr[wb_reg_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t    <= '0;
      r_sp   <= SP_RESET;
      r_ih   <= '0;
      r_ra   <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_we.t_we)  r_t  <= wb_data;
      if (w_we.sp_we) r_sp <= wb_data;
      if (w_we.ih_we) r_ih <= wb_data;
      if (w_we.ra_we) r_ra <= wb_data;
      r_done <= w_commit_done;
      r_err  <= r_err | w_err;
    end
  end

`ifdef WB_REG_BYPASS_EN
  // Write enables already carry the full commit condition.
  always_comb begin
    data_REGA = (w_we.reg_we && (wb_reg_idx == rx_idx)) ? wb_data : r_gpr[rx_idx];
    data_REGB = (w_we.reg_we && (wb_reg_idx == ry_idx)) ? wb_data : r_gpr[ry_idx];
    data_T    = w_we.t_we  ? wb_data : r_t;
    data_SP   = w_we.sp_we ? wb_data : r_sp;
    data_IH   = w_we.ih_we ? wb_data : r_ih;
    data_RA   = w_we.ra_we ? wb_data : r_ra;
  end
`else
  always_comb begin
    data_REGA = r_gpr[rx_idx];
    data_REGB = r_gpr[ry_idx];
    data_T    = r_t;
    data_SP   = r_sp;
    data_IH   = r_ih;
    data_RA   = r_ra;
  end
`endif

  assign wb_done = r_done;
  assign wb_err  = r_err;

endmodule
